// File: rtl/fft_reorder.sv
// Streaming bit-reversal reorder buffer: two ping-pong banks, natural-order output with rdy.
// Optional FFT_REORDER_SOF_EN adds sof_a to restart the current write frame.
module fft_reorder #(
   parameter int unsigned LOG2N = 6,
   parameter int unsigned WIDTH = 11
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             valid_a,
`ifdef FFT_REORDER_SOF_EN
   input  logic             sof_a,
`endif
   input  logic [WIDTH-1:0] ar,
   input  logic [WIDTH-1:0] ai,
   input  logic             rdy,
   output logic             valid_o,
   output logic [WIDTH-1:0] xr,
   output logic [WIDTH-1:0] xi,
   output logic [LOG2N-1:0] idx,
   output logic             sof_o,
   output logic             ovf
);

   localparam int unsigned N = 1 << LOG2N;

   typedef enum logic [1:0] {StEmpty, StFilling, StFull, StReading} bank_state_e;

   logic [2*WIDTH-1:0] mem [2*N];
   bank_state_e        bank_q [2];
   logic               wbank_q;
   logic               rbank_q;
   logic [LOG2N-1:0]   wcnt_q;
   logic [LOG2N-1:0]   raddr_q;

   logic               issue;
   logic               last_issue;
   logic               can_write;
   logic               do_write;
   logic               sof_restart;
   logic [LOG2N-1:0]   wcnt_eff;
   logic [LOG2N-1:0]   waddr;
   logic [2*WIDTH-1:0] rdata;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   always_comb begin
      issue      = (bank_q[rbank_q] == StReading) && (!valid_o || rdy);
      last_issue = issue && (&raddr_q);
      // The bank being released this cycle is already free for the next frame's first sample.
      can_write  = (bank_q[wbank_q] == StEmpty) || (bank_q[wbank_q] == StFilling) ||
                   (last_issue && (rbank_q == wbank_q));
      do_write   = valid_a && can_write;
`ifdef FFT_REORDER_SOF_EN
      sof_restart = valid_a && sof_a;
`else
      sof_restart = 1'b0;
`endif
      wcnt_eff   = sof_restart ? '0 : wcnt_q;
      waddr      = bitrev(wcnt_eff);
      rdata      = mem[{rbank_q, raddr_q}];
   end

   always_ff @(posedge CLK) begin
      if (RST && do_write) mem[{wbank_q, waddr}] <= {ar, ai};
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         bank_q[0] <= StEmpty;
         bank_q[1] <= StEmpty;
         wbank_q   <= 1'b0;
         rbank_q   <= 1'b0;
         wcnt_q    <= '0;
         raddr_q   <= '0;
         valid_o   <= 1'b0;
         xr        <= '0;
         xi        <= '0;
         idx       <= '0;
         sof_o     <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (issue) begin
            valid_o  <= 1'b1;
            {xr, xi} <= rdata;
            idx      <= raddr_q;
            sof_o    <= (raddr_q == '0);
            if (&raddr_q) begin
               bank_q[rbank_q] <= StEmpty;
               rbank_q         <= ~rbank_q;
               raddr_q         <= '0;
               if (bank_q[~rbank_q] == StFull) bank_q[~rbank_q] <= StReading;
            end else begin
               raddr_q <= raddr_q + 1'b1;
            end
         end else begin
            if (rdy) begin
               valid_o <= 1'b0;
               sof_o   <= 1'b0;
            end
            if (bank_q[rbank_q] == StFull) bank_q[rbank_q] <= StReading;
         end

         // Write side comes last so a refill of the just-released bank wins over StEmpty.
         ovf <= 1'b0;
         if (valid_a) begin
            if (!can_write) begin
               ovf <= 1'b1;
            end else begin
               ovf <= sof_restart && (wcnt_q != '0);
               if (&wcnt_eff) begin
                  bank_q[wbank_q] <= StFull;
                  wbank_q         <= ~wbank_q;
                  wcnt_q          <= '0;
               end else begin
                  bank_q[wbank_q] <= StFilling;
                  wcnt_q          <= wcnt_eff + 1'b1;
               end
            end
         end
      end
   end

endmodule
